// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: opcode values and FSM encoding.
// Imported by the arbiter and the top-level sequencer.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [1:0] onehot2(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant from valid and the priority
// pointer, with the pointer moving past the winner on each accepted request.
module rr_arb2
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       enable,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic ptr;

  // The pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant_id = (valid == 2'b11) ? ptr : valid[1];
    grant    = (enable && (valid != 2'b00)) ? onehot2(grant_id) : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= ~grant_id;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external ALU between two requesters: round-robin accept, one EXEC
// cycle driving the ALU, then a held valid/ready response tagged with the requester.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_zero,
  output logic              rsp_id
);

  state_t            state;
  logic [1:0]        grant;
  logic              grant_id;
  logic              accept;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [CTRL_W-1:0] op_ctrl;
  logic              op_id;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (req_valid),
    .enable   (state == IDLE),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);

  // The op registers feed the ALU directly, so its inputs simply hold between ops.
  assign alu_a    = op_a;
  assign alu_b    = op_b;
  assign alu_ctrl = op_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      op_ctrl   <= CTRL_W'(OP_AND);
      op_id     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a    <= grant_id ? req1_a    : req0_a;
            op_b    <= grant_id ? req1_b    : req0_b;
            op_ctrl <= grant_id ? req1_ctrl : req0_ctrl;
            op_id   <= grant_id;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_result;
          rsp_zero  <= alu_zero;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU beside it and a
// scoreboard queue of expected responses pushed at issue time.
module tb_alu_share_ctrl;
  import alu_ctrl_pkg::*;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [WIDTH-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
  logic [WIDTH-1:0]  alu_a, alu_b, alu_result;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              alu_zero;
  logic              rsp_valid, rsp_ready, rsp_zero, rsp_id;
  logic [WIDTH-1:0]  rsp_data;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             id;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctrl  (req0_ctrl),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctrl  (req1_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .rsp_id     (rsp_id)
  );

  // Stand-in for the external ALU that sits next to the controller.
  always_comb begin
    alu_result = alu_a;
    case (alu_ctrl)
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_SLT:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = alu_a;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic rq, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] ctrl);
    if (rq) begin
      req1_a = a; req1_b = b; req1_ctrl = ctrl;
    end else begin
      req0_a = a; req0_b = b; req0_ctrl = ctrl;
    end
    req_valid[rq] = 1'b1;
  endtask

  task automatic pushExp(input logic [31:0] data, input logic zero, input logic id);
    rsp_t e;
    e.data = data;
    e.zero = zero;
    e.id   = id;
    exp_q.push_back(e);
  endtask

  // Leaves the caller just after a negedge in the cycle whose posedge performs the handshake.
  task automatic waitGrant(input string tag, input logic [1:0] expg);
    for (int n = 0; n < 20; n++) begin
      #1;
      if (req_ready != 2'b00) break;
      @(negedge clk);
    end
    checkOutput({tag, "_grant"}, {30'b0, req_ready}, {30'b0, expg});
  endtask

  task automatic waitRsp(input string tag);
    rsp_t e;
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_rsp_seen"}, {31'b0, rsp_valid}, 32'd1);
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput({tag, "_rsp_unexpected"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput({tag, "_data"}, rsp_data, e.data);
        checkOutput({tag, "_zero"}, {31'b0, rsp_zero}, {31'b0, e.zero});
        checkOutput({tag, "_id"},   {31'b0, rsp_id},   {31'b0, e.id});
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_a = '0; req1_b = '0; req1_ctrl = '0;
    repeat (2) @(negedge clk);

    checkOutput("rst_req_ready", {30'b0, req_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_data",  rsp_data, 32'd0);
    checkOutput("rst_rsp_zero",  {31'b0, rsp_zero}, 32'd0);
    checkOutput("rst_rsp_id",    {31'b0, rsp_id}, 32'd0);
    checkOutput("rst_alu_a",     alu_a, 32'd0);
    checkOutput("rst_alu_b",     alu_b, 32'd0);
    checkOutput("rst_alu_ctrl",  32'(alu_ctrl), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Lone requester 0 ADD, checking the EXEC-cycle ALU drive.
    applyStimulus(1'b0, 32'd5, 32'd7, OP_ADD);
    pushExp(32'd12, 1'b0, 1'b0);
    waitGrant("add", 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    checkOutput("add_alu_ctrl", 32'(alu_ctrl), 32'(OP_ADD));
    checkOutput("add_alu_a", alu_a, 32'd5);
    checkOutput("add_alu_b", alu_b, 32'd7);
    checkOutput("add_exec_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    waitRsp("add");

    applyStimulus(1'b1, 32'd9, 32'd9, OP_SUB);
    pushExp(32'd0, 1'b1, 1'b1);
    waitGrant("sub_eq", 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    waitRsp("sub_eq");

    applyStimulus(1'b1, 32'd3, 32'd5, OP_SUB);
    pushExp(32'hFFFF_FFFE, 1'b0, 1'b1);
    waitGrant("sub_neg", 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    waitRsp("sub_neg");

    // Both requesters held valid from a fresh reset: grants must alternate.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    applyStimulus(1'b0, 32'd1, 32'd1, OP_ADD);
    applyStimulus(1'b1, 32'h0000_00F0, 32'h0000_000F, OP_OR);
    for (int g = 0; g < 4; g++) begin
      if (g % 2 == 1) pushExp(32'h0000_00FF, 1'b0, 1'b1);
      else            pushExp(32'd2, 1'b0, 1'b0);
      waitGrant($sformatf("rr%0d", g), (g % 2 == 1) ? 2'b10 : 2'b01);
      @(negedge clk);
      waitRsp($sformatf("rr%0d", g));
    end
    req_valid = 2'b00;
    @(negedge clk);

    // Response back-pressure: held stable for four cycles, no new accept.
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 32'd3, 32'd5, OP_SLT);
    pushExp(32'd1, 1'b0, 1'b0);
    waitGrant("slt", 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    applyStimulus(1'b1, 32'h1234_5678, 32'hFFFF_0000, OP_AND);
    waitRsp("slt");
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("stall%0d_valid", i), {31'b0, rsp_valid}, 32'd1);
      checkOutput($sformatf("stall%0d_data", i), rsp_data, 32'd1);
      checkOutput($sformatf("stall%0d_id", i), {31'b0, rsp_id}, 32'd0);
      checkOutput($sformatf("stall%0d_req_ready", i), {30'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("stall_release_valid", {31'b0, rsp_valid}, 32'd0);

    // Reset during EXEC aborts the op and returns the pointer to requester 0.
    applyStimulus(1'b0, 32'd5, 32'd7, OP_ADD);
    waitGrant("abort", 2'b01);
    @(negedge clk);
    checkOutput("abort_exec_alu_a", alu_a, 32'd5);
    rst_n = 1'b0;
    req_valid = 2'b00;
    #1;
    checkOutput("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("abort_rsp_data",  rsp_data, 32'd0);
    checkOutput("abort_alu_a",     alu_a, 32'd0);
    checkOutput("abort_alu_ctrl",  32'(alu_ctrl), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("abort_quiet%0d", i), {31'b0, rsp_valid}, 32'd0);
    end
    applyStimulus(1'b0, 32'd5, 32'd7, OP_ADD);
    applyStimulus(1'b1, 32'd9, 32'd9, OP_SUB);
    pushExp(32'd12, 1'b0, 1'b0);
    waitGrant("post_abort", 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    waitRsp("post_abort");

    // Unsupported opcode passes through; the ALU returns a unchanged.
    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 4'b1111);
    pushExp(32'hDEAD_BEEF, 1'b0, 1'b1);
    waitGrant("unsup", 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    checkOutput("unsup_alu_ctrl", 32'(alu_ctrl), 32'hF);
    waitRsp("unsup");

    @(negedge clk);
    checkOutput("sb_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencer/arbiter that shares the single 32-bit ALU between two requesters (e.g. main datapath and a branch/address unit).
- Accepts ALU operations over valid/ready request channels and arbitrates round-robin.
- Drives the ALU operand and control inputs for exactly one cycle per operation.
- Registers the ALU result and zero flag, and returns them with a requester ID over a valid/ready response channel.

Parameters:
- WIDTH, 32, operand/result width.
- CTRL_W, 4, ALU control code width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester accept; at most one bit set.
- req0_a / req0_b  in  WIDTH  requester 0 operands.
- req0_ctrl  in  CTRL_W  requester 0 operation code.
- req1_a / req1_b  in  WIDTH  requester 1 operands.
- req1_ctrl  in  CTRL_W  requester 1 operation code.
- alu_a / alu_b  out  WIDTH  ALU operand inputs.
- alu_ctrl  out  CTRL_W  ALU control input.
- alu_result  in  WIDTH  ALU combinational result.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_data  out  WIDTH  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_id  out  1  requester that issued the operation.

Behaviour:
- Reset (async assert, sync-safe deassert) values:
  - state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_id=0.
  - alu_a=0, alu_b=0, alu_ctrl=0 (AND code, harmless).
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from req_valid and rr_ptr.
  - Only one requester valid: grant it.
  - Both valid: grant rr_ptr.
  - req_ready = one-hot grant, asserted only in IDLE.
  - On handshake: latch a/b/ctrl/id into op registers; rr_ptr <= ~granted id; go EXEC.
  - No valid: stay IDLE; rr_ptr unchanged.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_ctrl driven from op registers.
  - At clock edge: rsp_data<=alu_result, rsp_zero<=alu_zero, rsp_id<=op id; go RESP.
- RESP:
  - rsp_valid=1; rsp_data/rsp_zero/rsp_id held stable while rsp_ready=0.
  - On rsp_ready=1: go IDLE, rsp_valid deasserts next cycle.
  - req_ready=0 throughout; no new accept until IDLE.
- ALU inputs outside EXEC:
  - Hold last op-register values; no glitch requirement.
  - alu_result/alu_zero are sampled only in EXEC.
- Latency: request handshake at cycle N → ALU driven N+1 → rsp_valid from N+2. Minimum 3 cycles per op with rsp_ready tied high.
- Operation codes are passed through unmodified:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (zero=1 iff a==b), 0111 set-less-than (result 1/0).
  - Any other code: ALU returns a unchanged; the controller does not reject it.
- Arithmetic wraps modulo 2^WIDTH (ALU property); the controller adds no width extension.
- Requester must hold a/b/ctrl stable while its req_valid=1 and req_ready=0; sampling occurs only on handshake.
- Withdrawing req_valid before grant is legal; the grant is recomputed each IDLE cycle.
- rst_n assertion in EXEC or RESP aborts the op: no response is emitted, all state returns to reset values, and rr_ptr returns to 0.

Decomposition:
- Shared package alu_ctrl_pkg:
  - ALU opcode localparams OP_AND=4'b0000, OP_OR=4'b0001, OP_ADD=4'b0010, OP_SUB=4'b0110, OP_SLT=4'b0111.
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
- One sub-module: rr_arb2 (2-input round-robin grant from valid + pointer, combinational, plus pointer update on accept).
- The ALU itself stays outside, instantiated next to this block at the level above.

Test Plan:
- req0 ADD a=5 b=7 alone, rsp_ready=1 → req_ready=2'b01 in IDLE, alu_ctrl=0010 in EXEC, rsp_data=12, rsp_zero=0, rsp_id=0 two cycles after handshake.
- req1 SUB a=9 b=9 → rsp_data=0, rsp_zero=1, rsp_id=1; then SUB a=3 b=5 → rsp_data=32'hFFFF_FFFE, rsp_zero=0.
- Both valid continuously, req0 ADD 1+1, req1 OR F0|0F, from reset → grants alternate 0,1,0,1; responses rsp_id 0 then 1 with data 2 then 32'hFF.
- rsp_ready=0 for 4 cycles in RESP with SLT a=3 b=5 → rsp_valid stays 1, rsp_data=1 stable, req_ready=0 throughout; accept on 5th cycle → IDLE next.
- rst_n pulsed low during EXEC → rsp_valid never asserts, outputs at reset values immediately, next request granted to req0 when both valid.
- Unsupported ctrl 4'b1111 a=32'hDEAD_BEEF → rsp_data=32'hDEAD_BEEF, rsp_zero=0.
